// File: rtl/cf_overlay_px_if.sv
// AXI4-Stream video beat bundle (NPPC pixels per beat) shared by the overlay input and output.
interface cf_overlay_px_if #(
  parameter int NPPC       = 4,
  parameter int DATA_WIDTH = 24
) ();
  logic [NPPC*DATA_WIDTH-1:0] tdata;
  logic                       tvalid;
  logic                       tuser;
  logic                       tlast;
  logic                       tready;

  modport master (output tdata, output tvalid, output tuser, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast, output tready);
endinterface

// File: rtl/cf_overlay_px.sv
// Box outline / centre cross overlay for the tracker video path, NPPC pixels per beat.
// Position, colour and mode are frame-synchronous; output is served from a 2-entry skid buffer.
module cf_overlay_px #(
  parameter int NPPC           = 4,
  parameter int DATA_WIDTH     = 24,
  parameter int POSITION_WIDTH = 12,
  parameter int FFT_LENGTH     = 64,
  parameter int HEIGHT         = 2160,
  parameter int CROSS_HALF     = 2
) (
  input  logic                      s_axis_video_aclk,
  input  logic                      s_axis_video_areset,
  cf_overlay_px_if.slave            VIDEO_IN,
  cf_overlay_px_if.master           VIDEO_OUT,
  input  logic [POSITION_WIDTH-1:0] xStart,
  input  logic [POSITION_WIDTH-1:0] yStart,
  input  logic [DATA_WIDTH-1:0]     color,
  input  logic [1:0]                mode
);
  localparam int W       = POSITION_WIDTH + 2;
  localparam int BW      = NPPC * DATA_WIDTH;
  localparam int EW      = BW + 2;
  localparam int NPPC_LG = $clog2(NPPC);
  localparam logic [W-1:0] L_M1   = W'(FFT_LENGTH - 1);
  localparam logic [W-1:0] L_HALF = W'(FFT_LENGTH / 2);
  localparam logic [W-1:0] CH     = W'(CROSS_HALF);
  localparam logic [POSITION_WIDTH-1:0] Y_LAST = POSITION_WIDTH'(HEIGHT - 1);

  logic clk;
  logic srst;
  assign clk  = s_axis_video_aclk;
  assign srst = s_axis_video_areset;

  logic [POSITION_WIDTH-1:0] x_word_q, x_word_d;
  logic [POSITION_WIDTH-1:0] y_pos_q, y_pos_d;
  logic [POSITION_WIDTH-1:0] xs_sh_q, ys_sh_q;
  logic [DATA_WIDTH-1:0]     color_sh_q;
  logic [1:0]                mode_sh_q;

  logic [EW-1:0] buf_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q, count_d;
  logic          in_ready_q;

  logic in_fire;
  logic out_fire;
  assign in_fire  = VIDEO_IN.tvalid && in_ready_q;
  assign out_fire = (count_q != 2'd0) && VIDEO_OUT.tready;

  // A tuser beat sees a zeroed position and the live controls; later beats use the shadows.
  logic [POSITION_WIDTH-1:0] eff_x_word, eff_y, eff_xs, eff_ys;
  logic [DATA_WIDTH-1:0]     eff_color;
  logic [1:0]                eff_mode;
  assign eff_x_word = VIDEO_IN.tuser ? '0     : x_word_q;
  assign eff_y      = VIDEO_IN.tuser ? '0     : y_pos_q;
  assign eff_xs     = VIDEO_IN.tuser ? xStart : xs_sh_q;
  assign eff_ys     = VIDEO_IN.tuser ? yStart : ys_sh_q;
  assign eff_color  = VIDEO_IN.tuser ? color  : color_sh_q;
  assign eff_mode   = VIDEO_IN.tuser ? mode   : mode_sh_q;

  always_comb begin
    x_word_d = x_word_q;
    y_pos_d  = y_pos_q;
    if (in_fire) begin
      if (VIDEO_IN.tlast) begin
        x_word_d = '0;
        y_pos_d  = (eff_y == Y_LAST) ? '0 : eff_y + 1'b1;
      end else begin
        x_word_d = eff_x_word + 1'b1;
        y_pos_d  = eff_y;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({in_fire, out_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Coordinates are widened by two bits and compared in rearranged form so nothing underflows.
  logic [W-1:0] x_base, y_w, xs_w, ys_w;
  assign x_base = W'(eff_x_word) << NPPC_LG;
  assign y_w    = W'(eff_y);
  assign xs_w   = W'(eff_xs);
  assign ys_w   = W'(eff_ys);

  logic y_in, y_edge, y_arm;
  assign y_in   = (y_w >= ys_w) && (y_w <= ys_w + L_M1);
  assign y_edge = (y_w == ys_w) || (y_w == ys_w + L_M1);
  assign y_arm  = (y_w + CH >= ys_w + L_HALF) && (y_w < ys_w + L_HALF + CH);

  logic [BW-1:0] px_out;

  generate
    for (genvar gi = 0; gi < NPPC; gi++) begin : g_px
      logic [W-1:0] x_w;
      logic         x_in, x_edge, x_arm, hit;
      assign x_w    = x_base + W'(gi);
      assign x_in   = (x_w >= xs_w) && (x_w <= xs_w + L_M1);
      assign x_edge = (x_w == xs_w) || (x_w == xs_w + L_M1);
      assign x_arm  = (x_w + CH >= xs_w + L_HALF) && (x_w < xs_w + L_HALF + CH);
      assign hit    = x_in && y_in &&
                      ((eff_mode[0] && (x_edge || y_edge)) || (eff_mode[1] && (x_arm || y_arm)));
      assign px_out[gi*DATA_WIDTH +: DATA_WIDTH] =
          hit ? eff_color : VIDEO_IN.tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      x_word_q   <= '0;
      y_pos_q    <= '0;
      xs_sh_q    <= '0;
      ys_sh_q    <= '0;
      color_sh_q <= '0;
      mode_sh_q  <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      x_word_q   <= x_word_d;
      y_pos_q    <= y_pos_d;
      count_q    <= count_d;
      in_ready_q <= (count_d <= 2'd1);
      if (in_fire) begin
        buf_q[wr_ptr_q] <= {VIDEO_IN.tuser, VIDEO_IN.tlast, px_out};
        wr_ptr_q        <= ~wr_ptr_q;
        if (VIDEO_IN.tuser) begin
          xs_sh_q    <= xStart;
          ys_sh_q    <= yStart;
          color_sh_q <= color;
          mode_sh_q  <= mode;
        end
      end
      if (out_fire) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign VIDEO_IN.tready  = in_ready_q;
  assign VIDEO_OUT.tvalid = (count_q != 2'd0);
  assign {VIDEO_OUT.tuser, VIDEO_OUT.tlast, VIDEO_OUT.tdata} = buf_q[rd_ptr_q];
endmodule

// File: tb/tb_cf_overlay_px.sv
// Self-checking bench for cf_overlay_px: a frame-level pixel model predicts every output beat.
`timescale 1ns/1ps
module tb_cf_overlay_px;
  localparam int NPPC   = 4;
  localparam int DW     = 24;
  localparam int PW     = 12;
  localparam int L      = 64;
  localparam int HEIGHT = 2160;
  localparam int CH     = 2;
  localparam int BW     = NPPC * DW;
  localparam int EW     = BW + 2;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic [PW-1:0] x_start = '0;
  logic [PW-1:0] y_start = '0;
  logic [DW-1:0] color = '0;
  logic [1:0]    mode = '0;

  always #5 clk = ~clk;

  cf_overlay_px_if #(.NPPC(NPPC), .DATA_WIDTH(DW)) vin ();
  cf_overlay_px_if #(.NPPC(NPPC), .DATA_WIDTH(DW)) vout ();

  cf_overlay_px #(
    .NPPC(NPPC), .DATA_WIDTH(DW), .POSITION_WIDTH(PW),
    .FFT_LENGTH(L), .HEIGHT(HEIGHT), .CROSS_HALF(CH)
  ) dut (
    .s_axis_video_aclk  (clk),
    .s_axis_video_areset(srst),
    .VIDEO_IN           (vin),
    .VIDEO_OUT          (vout),
    .xStart             (x_start),
    .yStart             (y_start),
    .color              (color),
    .mode               (mode)
  );

  int            checks = 0;
  int            errors = 0;
  int            rdy_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready
  logic [EW-1:0] exp_beat = '0;
  logic [EW-1:0] exp_q [$];
  int            inflight = 0;
  logic          stalled = 1'b0;
  logic [EW:0]   stall_snap = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pixel (x,y) takes the colour if it lies in the LxL box and on its outline or centre arms.
  function automatic logic [BW-1:0] model_px(input logic [BW-1:0] din, input int xw, input int y,
                                             input int xs, input int ys, input logic [DW-1:0] col,
                                             input logic [1:0] md);
    logic [BW-1:0] r;
    r = din;
    for (int k = 0; k < NPPC; k++) begin
      int x;
      bit inb, on_box, on_cross;
      x        = xw * NPPC + k;
      inb      = (x >= xs) && (x < xs + L) && (y >= ys) && (y < ys + L);
      on_box   = md[0] && (x == xs || x == xs + L - 1 || y == ys || y == ys + L - 1);
      on_cross = md[1] && ((x >= xs + L/2 - CH && x < xs + L/2 + CH) ||
                           (y >= ys + L/2 - CH && y < ys + L/2 + CH));
      if (inb && (on_box || on_cross)) r[k*DW +: DW] = col;
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < BW; i += 32) r = (r << 32) | BW'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       vout.tready = 1'b1;
      1:       vout.tready = ($urandom_range(0, 1) == 1);
      default: vout.tready = 1'b0;
    endcase
  endtask

  task automatic send_beat(input logic [BW-1:0] data, input logic user, input logic last,
                           input logic [EW-1:0] exp, input bit gaps);
    int n;
    bit acc;
    if (gaps && $urandom_range(0, 3) == 0) begin
      vin.tvalid = 1'b0;
      tick();
    end
    vin.tvalid = 1'b1;
    vin.tdata  = data;
    vin.tuser  = user;
    vin.tlast  = last;
    exp_beat   = exp;
    acc = 1'b0;
    n   = 0;
    while (!acc) begin
      @(negedge clk);
      acc = (vin.tready === 1'b1);
      tick();
      n++;
      if (!acc && n > 2000) begin
        check("in_ready_timeout", 128'(vin.tready), 128'(1));
        acc = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input int width, input int lines, input int xs, input int ys,
                            input logic [DW-1:0] col, input logic [1:0] md,
                            input int chg_line, input int chg_xs, input bit gaps);
    int bpl;
    bpl = width / NPPC;
    for (int y = 0; y < lines; y++) begin
      if (y == chg_line) begin
        x_start = PW'(chg_xs);
        y_start = y_start + 1'b1;
        color   = ~color;
        mode    = ~mode;
      end
      for (int b = 0; b < bpl; b++) begin
        logic [BW-1:0] d;
        logic u, l;
        d = rand_beat();
        u = (y == 0 && b == 0);
        l = (b == bpl - 1);
        if (u) begin
          x_start = PW'(xs);
          y_start = PW'(ys);
          color   = col;
          mode    = md;
        end
        send_beat(d, u, l, {u, l, model_px(d, b, y % HEIGHT, xs, ys, col, md)}, gaps);
      end
    end
    vin.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || vout.tvalid) && n < 5000) begin
      tick();
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // Output monitor: predicts valid/ready from beats in flight and pops the expected beat queue.
  always @(negedge clk) begin
    logic in_acc, out_acc;
    if (srst) begin
      exp_q.delete();
      inflight = 0;
      stalled  = 1'b0;
    end else begin
      in_acc  = vin.tvalid && vin.tready;
      out_acc = vout.tvalid && vout.tready;
      check("out_valid", 128'(vout.tvalid), 128'(inflight != 0));
      if (inflight >= 2) check("in_ready_when_full", 128'(vin.tready), 128'(0));
      if (stalled)
        check("hold_stable", 128'({vout.tvalid, vout.tuser, vout.tlast, vout.tdata}), 128'(stall_snap));
      if (out_acc) begin
        if (exp_q.size() == 0) check("out_unexpected", 128'(out_acc), 128'(0));
        else check("out_beat", 128'({vout.tuser, vout.tlast, vout.tdata}), 128'(exp_q.pop_front()));
      end
      if (in_acc) exp_q.push_back(exp_beat);
      inflight   = inflight + int'(in_acc) - int'(out_acc);
      stalled    = vout.tvalid && !vout.tready;
      stall_snap = {vout.tvalid, vout.tuser, vout.tlast, vout.tdata};
    end
  end

  initial begin
    logic [BW-1:0] d;
    vin.tvalid  = 1'b0;
    vin.tdata   = '0;
    vin.tuser   = 1'b0;
    vin.tlast   = 1'b0;
    vout.tready = 1'b1;
    srst        = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 128'(vout.tvalid), 128'(0));
    check("rst_in_ready", 128'(vin.tready), 128'(0));
    check("rst_out_data", 128'(vout.tdata), 128'(0));
    check("rst_out_user_last", 128'({vout.tuser, vout.tlast}), 128'(0));
    srst = 1'b0;
    tick();
    check("rst_release_ready", 128'(vin.tready), 128'(1));

    // Box only, then cross only, then a mid-frame xStart change followed by the next frame.
    send_frame(128, 70, 5, 2, 24'hFF0000, 2'd1, -1, 0, 1'b0);
    drain();
    send_frame(128, 70, 0, 0, 24'hFF0000, 2'd2, -1, 0, 1'b0);
    drain();
    send_frame(128, 70, 5, 2, 24'hFF0000, 2'd1, 20, 40, 1'b0);
    send_frame(128, 70, 40, 2, 24'hFF0000, 2'd1, -1, 0, 1'b0);
    drain();

    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      send_frame(128, 70, int'($urandom_range(0, 100)), int'($urandom_range(0, 10)),
                 DW'($urandom), 2'($urandom_range(0, 3)), (f == 1) ? 30 : -1, 77, 1'b1);
    end
    drain();

    rdy_mode = 0;
    send_frame(4096, 3, 4090, 0, 24'h00FF00, 2'd3, -1, 0, 1'b0);
    drain();

    rdy_mode = 1;
    send_frame(NPPC, HEIGHT + 40, 0, 0, 24'h0000FF, 2'd3, -1, 0, 1'b1);
    drain();
    send_frame(128, 4, 0, 0, 24'hFFFFFF, 2'd0, -1, 0, 1'b1);
    drain();

    // Reset with two beats held in the buffer, then a fresh frame.
    rdy_mode    = 2;
    vout.tready = 1'b0;
    x_start = 12'd3;
    y_start = 12'd0;
    color   = 24'h123456;
    mode    = 2'd3;
    d = rand_beat();
    send_beat(d, 1'b1, 1'b0, {1'b1, 1'b0, model_px(d, 0, 0, 3, 0, 24'h123456, 2'd3)}, 1'b0);
    d = rand_beat();
    send_beat(d, 1'b0, 1'b0, {1'b0, 1'b0, model_px(d, 1, 0, 3, 0, 24'h123456, 2'd3)}, 1'b0);
    vin.tvalid = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("rst_mid_out_valid", 128'(vout.tvalid), 128'(0));
    check("rst_mid_in_ready", 128'(vin.tready), 128'(0));
    tick();
    check("rst_mid_ready_rise", 128'(vin.tready), 128'(1));
    rdy_mode = 1;
    send_frame(128, 70, 10, 5, 24'hFF00FF, 2'd3, -1, 0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
